// File: rtl/mem_port_arbiter_if.sv
// Bundle of every bus signal around mem_port_arbiter: two requester ports and the memory port.
// Latency: none (wires only).
// Backpressure: requesters hold rd/wr/addr/wrdata stable until mN_gnt is seen.
//
// Modports:
//   slave  - the arbiter: samples requests and mem_rddata, drives grants, read returns and memory strobes.
//   master - the surrounding logic (cpu, loader/DMA, memory wrapper): the mirror image.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // requester 0 (CPU core)
    logic [AW-1:0] m0_addr;
    logic          m0_rd;
    logic          m0_wr;
    logic [DW-1:0] m0_wrdata;
    logic          m0_lock;
    logic          m0_gnt;
    logic          m0_rdvalid;
    logic [DW-1:0] m0_rddata;

    // requester 1 (program loader / debug DMA)
    logic [AW-1:0] m1_addr;
    logic          m1_rd;
    logic          m1_wr;
    logic [DW-1:0] m1_wrdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rdvalid;
    logic [DW-1:0] m1_rddata;

    // shared memory port
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wrdata;
    logic [DW-1:0] mem_rddata;

    modport slave (
        input  m0_addr, m0_rd, m0_wr, m0_wrdata, m0_lock,
        output m0_gnt, m0_rdvalid, m0_rddata,
        input  m1_addr, m1_rd, m1_wr, m1_wrdata, m1_lock,
        output m1_gnt, m1_rdvalid, m1_rddata,
        output mem_addr, mem_rd, mem_wr, mem_wrdata,
        input  mem_rddata
    );

    modport master (
        output m0_addr, m0_rd, m0_wr, m0_wrdata, m0_lock,
        input  m0_gnt, m0_rdvalid, m0_rddata,
        output m1_addr, m1_rd, m1_wr, m1_wrdata, m1_lock,
        input  m1_gnt, m1_rdvalid, m1_rddata,
        input  mem_addr, mem_rd, mem_wr, mem_wrdata,
        output mem_rddata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto one 16-bit memory port, with lock bursts and read-data return routing.
// Latency: grant and memory strobes are combinational in the request cycle; read data returns RD_LAT cycles later.
// Backpressure: a requester that is not granted simply sees mN_gnt=0 and must hold its request stable.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - mem_port_arbiter_if.slave: m0_*/m1_* requester ports and mem_* memory port
//
// Parameters: AW/DW address/data width, RD_LAT memory read latency (legal 1..4).
// Build option: define MEM_ARB_RR_EN for round-robin tie-break; without it port 0 always wins ties.
module mem_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    // ------------------------------------------------------------------
    // Ownership state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Read-return tracking: index 0 is the newest entry, RD_LAT-1 is the tail
    // that lines up with mem_rddata.
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] rd_id_q,  rd_id_d;

`ifdef MEM_ARB_RR_EN
    // Port that received the most recent grant; reset to 1 so port 0 wins the first tie.
    logic last_gnt_q, last_gnt_d;
`endif

    logic          req0, req1;
    logic          tie_to_1;
    logic          gnt0, gnt1;
    logic          rd_push;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wrdata_mux;
    logic          rd_tail_vld;
    logic          rd_tail_id;

    // ------------------------------------------------------------------
    // Arbitration and next state
    // ------------------------------------------------------------------
    always_comb begin
        req0 = bus.m0_rd | bus.m0_wr;
        req1 = bus.m1_rd | bus.m1_wr;

`ifdef MEM_ARB_RR_EN
        // Give the tie to the port that did not win most recently.
        tie_to_1 = ~last_gnt_q;
`else
        tie_to_1 = 1'b0;
`endif

        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;

        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !tie_to_1)) begin
                    gnt0 = 1'b1;
                end else if (req1) begin
                    gnt1 = 1'b1;
                end
            end
            // The owner alone may be granted; the other port waits even if the owner is idle.
            OWN0: gnt0 = req0;
            OWN1: gnt1 = req1;
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase

        // Grants are forced low while reset is held so nothing reaches memory.
        gnt0 = gnt0 & reset;
        gnt1 = gnt1 & reset;

        case (state_q)
            IDLE: begin
                // Lock only matters on the port that actually got the grant.
                if (gnt0 && bus.m0_lock) begin
                    state_d = OWN0;
                end else if (gnt1 && bus.m1_lock) begin
                    state_d = OWN1;
                end
            end
            // Release happens at the edge where lock is seen low; a grant in that
            // last cycle has already been issued above.
            OWN0: if (!bus.m0_lock) state_d = IDLE;
            OWN1: if (!bus.m1_lock) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Memory port mux
    // ------------------------------------------------------------------
    always_comb begin
        addr_mux   = '0;
        wrdata_mux = '0;
        if (gnt0) begin
            addr_mux   = bus.m0_addr;
            wrdata_mux = bus.m0_wrdata;
        end else if (gnt1) begin
            addr_mux   = bus.m1_addr;
            wrdata_mux = bus.m1_wrdata;
        end
    end

    assign bus.mem_addr   = addr_mux;
    assign bus.mem_wrdata = wrdata_mux;
    // rd together with wr is treated as a write; the read is dropped.
    assign bus.mem_wr     = (gnt0 & bus.m0_wr) | (gnt1 & bus.m1_wr);
    assign bus.mem_rd     = (gnt0 & bus.m0_rd & ~bus.m0_wr) | (gnt1 & bus.m1_rd & ~bus.m1_wr);

    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;

    // ------------------------------------------------------------------
    // Read-return pipeline
    // ------------------------------------------------------------------
    assign rd_push = bus.mem_rd;

    always_comb begin
        rd_vld_d    = '0;
        rd_id_d     = '0;
        rd_vld_d[0] = rd_push;
        // id is only meaningful with valid; keep it 0 otherwise.
        rd_id_d[0]  = rd_push & gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_id_d[i]  = rd_id_q[i-1];
        end
    end

    assign rd_tail_vld = rd_vld_q[RD_LAT-1];
    assign rd_tail_id  = rd_id_q[RD_LAT-1];

    assign bus.m0_rdvalid = rd_tail_vld & ~rd_tail_id;
    assign bus.m1_rdvalid = rd_tail_vld &  rd_tail_id;
    // Data is broadcast to both ports; rdvalid alone says whose it is.
    assign bus.m0_rddata  = bus.mem_rddata;
    assign bus.m1_rddata  = bus.mem_rddata;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rd_vld_q <= '0;
            rd_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with RD_LAT = 1, 2, 3 share one stimulus set.
// A table of per-cycle vectors drives the RD_LAT=1 instance; hand sequences cover latency and reset.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    // shared requester stimulus
    logic        m0_rd, m0_wr, m0_lock, m1_rd, m1_wr, m1_lock;
    logic [15:0] m0_addr, m0_wrdata, m1_addr, m1_wrdata;

    // collected outputs, index = RD_LAT-1
    logic [2:0]  gnt0_v, gnt1_v, mrd_v, mwr_v, rdv0_v, rdv1_v;
    logic [15:0] maddr_v [3];
    logic [15:0] mwd_v   [3];
    logic [15:0] rdd0_v  [3];
    logic [15:0] rdd1_v  [3];

    int n_tests;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content model.
    function automatic logic [15:0] memf(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return a ^ 16'h5A5A;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter_if #(.AW(16), .DW(16)) bif ();
        logic [15:0] pipe [4];

        mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(g + 1)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bif)
        );

        assign bif.m0_addr   = m0_addr;
        assign bif.m0_rd     = m0_rd;
        assign bif.m0_wr     = m0_wr;
        assign bif.m0_wrdata = m0_wrdata;
        assign bif.m0_lock   = m0_lock;
        assign bif.m1_addr   = m1_addr;
        assign bif.m1_rd     = m1_rd;
        assign bif.m1_wr     = m1_wr;
        assign bif.m1_wrdata = m1_wrdata;
        assign bif.m1_lock   = m1_lock;

        // Memory stub: data for a read appears RD_LAT cycles after mem_rd, junk otherwise.
        always @(posedge clk) begin
            pipe[0] <= bif.mem_rd ? memf(bif.mem_addr) : 16'hDEAD;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign bif.mem_rddata = pipe[g];

        assign gnt0_v[g]  = bif.m0_gnt;
        assign gnt1_v[g]  = bif.m1_gnt;
        assign mrd_v[g]   = bif.mem_rd;
        assign mwr_v[g]   = bif.mem_wr;
        assign rdv0_v[g]  = bif.m0_rdvalid;
        assign rdv1_v[g]  = bif.m1_rdvalid;
        assign maddr_v[g] = bif.mem_addr;
        assign mwd_v[g]   = bif.mem_wrdata;
        assign rdd0_v[g]  = bif.m0_rddata;
        assign rdd1_v[g]  = bif.m1_rddata;
    end

    typedef struct {
        logic        rd0, wr0, lk0;
        logic [15:0] a0, d0;
        logic        rd1, wr1, lk1;
        logic [15:0] a1, d1;
        logic        g0, g1, mrd, mwr;
        logic [15:0] maddr, mwd;
        logic        v0, v1;
        logic [15:0] rdat;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    function automatic vec_t mkv(
        input logic rd0, wr0, lk0, input logic [15:0] a0, d0,
        input logic rd1, wr1, lk1, input logic [15:0] a1, d1,
        input logic g0, g1, mrd, mwr, input logic [15:0] maddr, mwd,
        input logic v0, v1, input logic [15:0] rdat);
        vec_t t;
        t.rd0 = rd0; t.wr0 = wr0; t.lk0 = lk0; t.a0 = a0; t.d0 = d0;
        t.rd1 = rd1; t.wr1 = wr1; t.lk1 = lk1; t.a1 = a1; t.d1 = d1;
        t.g0 = g0; t.g1 = g1; t.mrd = mrd; t.mwr = mwr; t.maddr = maddr; t.mwd = mwd;
        t.v0 = v0; t.v1 = v1; t.rdat = rdat;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_rd = 0; m0_wr = 0; m0_lock = 0; m0_addr = 0; m0_wrdata = 0;
        m1_rd = 0; m1_wr = 0; m1_lock = 0; m1_addr = 0; m1_wrdata = 0;
    endtask

    task automatic apply(input vec_t t);
        m0_rd = t.rd0; m0_wr = t.wr0; m0_lock = t.lk0; m0_addr = t.a0; m0_wrdata = t.d0;
        m1_rd = t.rd1; m1_wr = t.wr1; m1_lock = t.lk1; m1_addr = t.a1; m1_wrdata = t.d1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // ---- vector table (RD_LAT=1 instance) ----
        //                rd0 wr0 lk0 a0      d0       rd1 wr1 lk1 a1       d1        g0 g1 mrd mwr maddr    mwd      v0 v1 rdat
        vt[0]  = mkv(0, 0, 0, 16'h0,  16'h0,   0, 0, 0, 16'h0,   16'h0,    0, 0, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0);
        // tie: both ports read continuously
        vt[1]  = mkv(1, 0, 0, 16'h10, 16'h0,   1, 0, 0, 16'h20,  16'h0,    1, 0, 1, 0, 16'h10,  16'h0,   0, 0, 16'h0);
`ifdef MEM_ARB_RR_EN
        vt[2]  = mkv(1, 0, 0, 16'h10, 16'h0,   1, 0, 0, 16'h20,  16'h0,    0, 1, 1, 0, 16'h20,  16'h0,   1, 0, memf(16'h10));
        vt[3]  = mkv(1, 0, 0, 16'h10, 16'h0,   1, 0, 0, 16'h20,  16'h0,    1, 0, 1, 0, 16'h10,  16'h0,   0, 1, memf(16'h20));
        vt[4]  = mkv(1, 0, 0, 16'h10, 16'h0,   1, 0, 0, 16'h20,  16'h0,    0, 1, 1, 0, 16'h20,  16'h0,   1, 0, memf(16'h10));
        vt[5]  = mkv(0, 0, 0, 16'h0,  16'h0,   0, 0, 0, 16'h0,   16'h0,    0, 0, 0, 0, 16'h0,   16'h0,   0, 1, memf(16'h20));
`else
        vt[2]  = mkv(1, 0, 0, 16'h10, 16'h0,   1, 0, 0, 16'h20,  16'h0,    1, 0, 1, 0, 16'h10,  16'h0,   1, 0, memf(16'h10));
        vt[3]  = mkv(1, 0, 0, 16'h10, 16'h0,   1, 0, 0, 16'h20,  16'h0,    1, 0, 1, 0, 16'h10,  16'h0,   1, 0, memf(16'h10));
        vt[4]  = mkv(1, 0, 0, 16'h10, 16'h0,   1, 0, 0, 16'h20,  16'h0,    1, 0, 1, 0, 16'h10,  16'h0,   1, 0, memf(16'h10));
        vt[5]  = mkv(0, 0, 0, 16'h0,  16'h0,   0, 0, 0, 16'h0,   16'h0,    0, 0, 0, 0, 16'h0,   16'h0,   1, 0, memf(16'h10));
`endif
        // single read 0x0040 -> 0xBEEF
        vt[6]  = mkv(1, 0, 0, 16'h40, 16'h0,   0, 0, 0, 16'h0,   16'h0,    1, 0, 1, 0, 16'h40,  16'h0,   0, 0, 16'h0);
        vt[7]  = mkv(0, 0, 0, 16'h0,  16'h0,   0, 0, 0, 16'h0,   16'h0,    0, 0, 0, 0, 16'h0,   16'h0,   1, 0, 16'hBEEF);
        // lock burst by port 1 (writes), port 0 waits
        vt[8]  = mkv(0, 0, 0, 16'h0,  16'h0,   0, 1, 1, 16'h100, 16'h1234, 0, 1, 0, 1, 16'h100, 16'h1234, 0, 0, 16'h0);
        vt[9]  = mkv(1, 0, 0, 16'h30, 16'h0,   0, 1, 1, 16'h100, 16'h1234, 0, 1, 0, 1, 16'h100, 16'h1234, 0, 0, 16'h0);
        vt[10] = mkv(1, 0, 0, 16'h30, 16'h0,   0, 1, 1, 16'h100, 16'h1234, 0, 1, 0, 1, 16'h100, 16'h1234, 0, 0, 16'h0);
        // lock dropped while still owning: port 0 still waits this cycle
        vt[11] = mkv(1, 0, 0, 16'h30, 16'h0,   0, 0, 0, 16'h0,   16'h0,    0, 0, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0);
        vt[12] = mkv(1, 0, 0, 16'h30, 16'h0,   0, 0, 0, 16'h0,   16'h0,    1, 0, 1, 0, 16'h30,  16'h0,   0, 0, 16'h0);
        vt[13] = mkv(0, 0, 0, 16'h0,  16'h0,   0, 0, 0, 16'h0,   16'h0,    0, 0, 0, 0, 16'h0,   16'h0,   1, 0, memf(16'h30));
        // rd and wr together: a write, no read return
        vt[14] = mkv(1, 1, 0, 16'h50, 16'h00AA, 0, 0, 0, 16'h0,  16'h0,    1, 0, 0, 1, 16'h50,  16'h00AA, 0, 0, 16'h0);
        vt[15] = mkv(0, 0, 0, 16'h0,  16'h0,   0, 0, 0, 16'h0,   16'h0,    0, 0, 0, 0, 16'h0,   16'h0,   0, 0, 16'h0);
        // lock on a non-granted, non-requesting port must not capture ownership
        vt[16] = mkv(1, 0, 0, 16'h10, 16'h0,   0, 0, 1, 16'h0,   16'h0,    1, 0, 1, 0, 16'h10,  16'h0,   0, 0, 16'h0);
        vt[17] = mkv(1, 0, 0, 16'h10, 16'h0,   0, 0, 0, 16'h0,   16'h0,    1, 0, 1, 0, 16'h10,  16'h0,   1, 0, memf(16'h10));
        vt[18] = mkv(0, 0, 0, 16'h0,  16'h0,   0, 0, 0, 16'h0,   16'h0,    0, 0, 0, 0, 16'h0,   16'h0,   1, 0, memf(16'h10));

        // ---- reset state, with requests pending ----
        idle_inputs();
        reset = 1'b0;
        m0_rd = 1; m1_rd = 1; m0_lock = 1; m0_addr = 16'h10; m1_addr = 16'h20;
        tick();
        tick();
        #4;
        chk("reset gnt0",     32'(gnt0_v[0]), 32'd0);
        chk("reset gnt1",     32'(gnt1_v[0]), 32'd0);
        chk("reset mem_rd",   32'(mrd_v[0]),  32'd0);
        chk("reset mem_wr",   32'(mwr_v[0]),  32'd0);
        chk("reset mem_addr", 32'(maddr_v[0]), 32'd0);
        chk("reset rdvalid0", 32'(rdv0_v[0]), 32'd0);
        chk("reset rdvalid1", 32'(rdv1_v[0]), 32'd0);
        tick();
        idle_inputs();
        reset = 1'b1;

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            apply(vt[i]);
            #4;
            chk($sformatf("row%0d gnt0", i),    32'(gnt0_v[0]),  32'(vt[i].g0));
            chk($sformatf("row%0d gnt1", i),    32'(gnt1_v[0]),  32'(vt[i].g1));
            chk($sformatf("row%0d mem_rd", i),  32'(mrd_v[0]),   32'(vt[i].mrd));
            chk($sformatf("row%0d mem_wr", i),  32'(mwr_v[0]),   32'(vt[i].mwr));
            chk($sformatf("row%0d mem_addr", i), 32'(maddr_v[0]), 32'(vt[i].maddr));
            chk($sformatf("row%0d mem_wrdata", i), 32'(mwd_v[0]), 32'(vt[i].mwd));
            chk($sformatf("row%0d rdvalid0", i), 32'(rdv0_v[0]), 32'(vt[i].v0));
            chk($sformatf("row%0d rdvalid1", i), 32'(rdv1_v[0]), 32'(vt[i].v1));
            if (vt[i].v0) chk($sformatf("row%0d rddata0", i), 32'(rdd0_v[0]), 32'(vt[i].rdat));
            if (vt[i].v1) chk($sformatf("row%0d rddata1", i), 32'(rdd1_v[0]), 32'(vt[i].rdat));
            tick();
        end

        // let earlier reads drain out of the longer pipelines
        idle_inputs();
        repeat (4) tick();

        // ---- RD_LAT=3: read on port 0 then port 1 on consecutive cycles ----
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            if (c == 0) begin m0_rd = 1; m0_addr = 16'h0010; end
            if (c == 1) begin m1_rd = 1; m1_addr = 16'h0020; end
            #4;
            chk($sformatf("lat3 c%0d gnt0", c),     32'(gnt0_v[2]), 32'(c == 0));
            chk($sformatf("lat3 c%0d gnt1", c),     32'(gnt1_v[2]), 32'(c == 1));
            chk($sformatf("lat3 c%0d rdvalid0", c), 32'(rdv0_v[2]), 32'(c == 3));
            chk($sformatf("lat3 c%0d rdvalid1", c), 32'(rdv1_v[2]), 32'(c == 4));
            if (c == 3) chk("lat3 rddata0", 32'(rdd0_v[2]), 32'(memf(16'h0010)));
            if (c == 4) chk("lat3 rddata1", 32'(rdd1_v[2]), 32'(memf(16'h0020)));
            tick();
        end
        idle_inputs();
        repeat (2) tick();

        // ---- RD_LAT=2: reset asserted while a read is in flight ----
        m0_rd = 1; m0_addr = 16'h0040;
        #4;
        chk("lat2 pre-reset gnt0", 32'(gnt0_v[1]), 32'd1);
        tick();
        reset = 1'b0;
        m0_rd = 1; m1_rd = 1; m0_addr = 16'h0010; m1_addr = 16'h0020; m1_wr = 1; m1_wrdata = 16'h5555;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk($sformatf("lat2 in-reset c%0d gnt0", c),     32'(gnt0_v[1]), 32'd0);
            chk($sformatf("lat2 in-reset c%0d gnt1", c),     32'(gnt1_v[1]), 32'd0);
            chk($sformatf("lat2 in-reset c%0d mem_rd", c),   32'(mrd_v[1]),  32'd0);
            chk($sformatf("lat2 in-reset c%0d mem_wr", c),   32'(mwr_v[1]),  32'd0);
            chk($sformatf("lat2 in-reset c%0d mem_addr", c), 32'(maddr_v[1]), 32'd0);
            chk($sformatf("lat2 in-reset c%0d mem_wrdata", c), 32'(mwd_v[1]), 32'd0);
            chk($sformatf("lat2 in-reset c%0d rdvalid0", c), 32'(rdv0_v[1]), 32'd0);
            chk($sformatf("lat2 in-reset c%0d rdvalid1", c), 32'(rdv1_v[1]), 32'd0);
            tick();
        end
        reset = 1'b1;
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            #4;
            chk($sformatf("lat2 post-reset c%0d rdvalid0", c), 32'(rdv0_v[1]), 32'd0);
            chk($sformatf("lat2 post-reset c%0d rdvalid1", c), 32'(rdv1_v[1]), 32'd0);
            tick();
        end
        m0_rd = 1; m0_addr = 16'h0010;
        m1_rd = 1; m1_addr = 16'h0020;
        #4;
        chk("lat2 post-reset tie gnt0", 32'(gnt0_v[1]), 32'd1);
        chk("lat2 post-reset tie gnt1", 32'(gnt1_v[1]), 32'd0);
        tick();
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit memory port between two requesters: port 0 is the CPU core and port 1 is the program loader / debug DMA.
- Arbitrates each cycle and supports lock-based bursts.
- Drives the one memory interface and routes read data back to the requester that issued the read, after a fixed memory read latency.
- Sits between the cpu block and the memory wrapper at the top level.

Parameters:
AW, 16, address width
DW, 16, data width
RD_LAT, 1, memory read latency in cycles from mem_rd to valid mem_rddata; legal range 1..4

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset; port keeps the codebase name "reset", polarity is low-active
m0_addr  in  AW  port 0 address
m0_rd  in  1  port 0 read request
m0_wr  in  1  port 0 write request
m0_wrdata  in  DW  port 0 write data
m0_lock  in  1  port 0 keeps ownership after the current grant
m0_gnt  out  1  port 0 access accepted this cycle
m0_rdvalid  out  1  port 0 read data valid
m0_rddata  out  DW  port 0 read data
m1_addr, m1_rd, m1_wr, m1_wrdata, m1_lock, m1_gnt, m1_rdvalid, m1_rddata  same as port 0, for port 1
mem_addr  out  AW  memory address
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_wrdata  out  DW  memory write data
mem_rddata  in  DW  memory read data, valid RD_LAT cycles after mem_rd

Behaviour:
- Request definition
  - reqN = mN_rd | mN_wr.
  - If rd and wr are both high, the access is a write and rd is ignored.
- Grant timing
  - At most one grant per cycle.
  - mN_gnt is combinational from the requests and registered state.
  - An access is complete in the cycle it is granted.
  - A requester not granted must hold its request, address and data stable until granted.
- Memory outputs
  - Combinationally muxed from the granted port.
  - With no grant: mem_addr=0, mem_wrdata=0, mem_rd=0, mem_wr=0.
- State machine: IDLE, OWN0, OWN1
  - IDLE:
    - If one port requests, grant it.
    - If both request, the round-robin pointer decides: grant the port not granted most recently.
  - Lock entry: if the granted port N has mN_lock=1 in its grant cycle, next state is OWNN.
  - OWNN:
    - Only port N may be granted; the other port waits even if port N is idle.
    - When mN_lock is sampled 0, return to IDLE at that edge.
    - A grant in that same cycle is still allowed.
  - Lock on a non-granted port has no effect.
- Round-robin pointer
  - last_gnt updates on every grant.
  - Reset value 1, so port 0 wins the first tie.
- Read return
  - A shift register of RD_LAT entries tracks {valid, id}.
  - A granted read pushes {1, N}; any other cycle pushes {0, x}.
  - mN_rdvalid = tail.valid & (tail.id == N).
  - mN_rddata = mem_rddata on both ports; only rdvalid qualifies it.
  - Back-to-back reads from alternating ports return in issue order, one per cycle, with no bubbles.
  - Writes never produce rdvalid.
- Reset
  - State IDLE, last_gnt=1, shift register cleared.
  - All gnt, rdvalid and mem strobe outputs are 0.
  - Reset asserted mid-read drops all in-flight returns; no rdvalid is ever produced for them after reset deasserts.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin tie-break as above.
- Undefined:
  - Fixed priority, port 0 always wins ties in IDLE.
  - last_gnt logic is removed.
  - Lock/OWN behaviour and read return are unchanged.

Test Plan:
1. Single read: RD_LAT=1, m0_rd=1, m0_addr=0x0040, mem returns 0xBEEF -> m0_gnt=1 in the same cycle, mem_addr=0x0040, mem_rd=1; next cycle m0_rdvalid=1, m0_rddata=0xBEEF, m1_rdvalid=0.
2. Tie alternation: both ports read continuously (m0 addr 0x10, m1 addr 0x20) for 4 cycles -> grants 0,1,0,1; rdvalid alternates m0, m1, m0, m1 with the matching data. With MEM_ARB_RR_EN undefined -> grants 0,0,0,0.
3. Lock burst: m1 writes 0x1234 to 0x0100 with m1_lock=1 for 3 cycles while m0_rd=1 -> m1 granted 3 cycles, m0_gnt=0 throughout; lock drops -> m0 granted the next cycle.
4. Simultaneous rd and wr: m0_rd=1, m0_wr=1, m0_wrdata=0x00AA -> mem_wr=1, mem_rd=0, no rdvalid afterwards.
5. Latency sweep: RD_LAT=3, reads to port 0 then port 1 on consecutive cycles -> m0_rdvalid 3 cycles after its grant, m1_rdvalid 1 cycle later.
6. Reset mid-read: RD_LAT=2, read granted, reset driven low the next cycle -> all outputs 0 during reset; after release no rdvalid appears and state is IDLE (port 0 wins the next tie).
